// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one sprite ROM between player and ghosts; optional collision flag via SPRITE_ARB_COLLIDE_EN
module sprite_rom_arbiter #(
  parameter int NUM_SPR = 5,
  parameter int SIZE    = 42,
  parameter int ADDR_W  = 14,
  parameter int ID_W    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              h_cnt,
  input  logic [9:0]              v_cnt,
  input  logic                    pix_valid,
  input  logic                    frame_start,
  input  logic [NUM_SPR-1:0]      sprite_en,
  input  logic [NUM_SPR*10-1:0]   sprite_x,
  input  logic [NUM_SPR*10-1:0]   sprite_y,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    rom_en,
  output logic [ID_W-1:0]         hit_id,
  output logic                    data_valid,
  output logic [ID_W-1:0]         data_id
`ifdef SPRITE_ARB_COLLIDE_EN
  ,
  output logic                    collide
`endif
);
  logic [NUM_SPR-1:0]        sh_en;
  logic [NUM_SPR*10-1:0]     sh_x, sh_y;
  logic [NUM_SPR-1:0]        hit_c, hit1;
  logic [NUM_SPR-1:0][5:0]   col_c, row_c, col1, row1;
  logic [ADDR_W-1:0]         addr_c;
  logic [ID_W-1:0]           id_c;
  logic                      en_c;
  // Frame-synchronous shadow copy of sprite positions so a frame never tears
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_en <= '0;
      sh_x  <= '0;
      sh_y  <= '0;
    end else if (frame_start) begin
      sh_en <= sprite_en;
      sh_x  <= sprite_x;
      sh_y  <= sprite_y;
    end
  // Per-sprite bounding-box test; upper bounds at 11 bits so sprites near 1023 clip instead of wrapping
  always_comb begin
    hit_c = '0;
    col_c = '0;
    row_c = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      hit_c[i] = sh_en[i] && pix_valid &&
                 h_cnt >= sh_x[10*i +: 10] && {1'b0, h_cnt} < 11'(sh_x[10*i +: 10]) + 11'(SIZE) &&
                 v_cnt >= sh_y[10*i +: 10] && {1'b0, v_cnt} < 11'(sh_y[10*i +: 10]) + 11'(SIZE);
      col_c[i] = 6'(h_cnt - sh_x[10*i +: 10]);
      row_c[i] = 6'(v_cnt - sh_y[10*i +: 10]);
    end
  end
  // Stage 1: hit vector and sprite-local coordinates
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit1 <= '0;
      col1 <= '0;
      row1 <= '0;
    end else begin
      hit1 <= hit_c;
      col1 <= col_c;
      row1 <= row_c;
    end
  // Lowest index wins: scan downward so the last assignment is the highest priority
  always_comb begin
    addr_c = '0;
    id_c   = '0;
    en_c   = 1'b0;
    for (int i = NUM_SPR - 1; i >= 0; i--)
      if (hit1[i]) begin
        addr_c = ADDR_W'(i * SIZE * SIZE) + ADDR_W'(row1[i]) * ADDR_W'(SIZE) + ADDR_W'(col1[i]);
        id_c   = ID_W'(i);
        en_c   = 1'b1;
      end
  end
  // Stage 2 drives the ROM; stage 3 tags the data returning one cycle later
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rom_addr   <= '0;
      rom_en     <= 1'b0;
      hit_id     <= '0;
      data_valid <= 1'b0;
      data_id    <= '0;
    end else begin
      rom_addr   <= addr_c;
      rom_en     <= en_c;
      hit_id     <= id_c;
      data_valid <= rom_en;
      data_id    <= hit_id;
    end
`ifdef SPRITE_ARB_COLLIDE_EN
  logic flag;
  logic coll_now;
  assign coll_now = hit1[0] && |hit1[NUM_SPR-1:1];
  // Sticky player/ghost overlap flag, reported and restarted at each frame boundary
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flag    <= 1'b0;
      collide <= 1'b0;
    end else begin
      collide <= frame_start && flag;
      flag    <= frame_start ? coll_now : (flag || coll_now);
    end
`endif
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed self-checking bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  h_cnt = '0, v_cnt = '0;
  logic        pix_valid = 1'b0, frame_start = 1'b0;
  logic [4:0]  sprite_en = '0;
  logic [49:0] sprite_x = '0, sprite_y = '0;
  logic [13:0] rom_addr;
  logic        rom_en, data_valid;
  logic [2:0]  hit_id, data_id;
  int          compared = 0, mismatched = 0;
`ifdef SPRITE_ARB_COLLIDE_EN
  logic        collide;
`endif

  sprite_rom_arbiter dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .pix_valid(pix_valid),
    .frame_start(frame_start), .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .rom_addr(rom_addr), .rom_en(rom_en), .hit_id(hit_id), .data_valid(data_valid), .data_id(data_id)
`ifdef SPRITE_ARB_COLLIDE_EN
    , .collide(collide)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic place(input int i, input int x, input int y);
    sprite_x[10*i +: 10] = 10'(x);
    sprite_y[10*i +: 10] = 10'(y);
  endtask

  task automatic latch(input logic [4:0] en);
    sprite_en = en;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // One visible pixel, then idle; on return stage-2 outputs for that pixel are visible
  task automatic probe(input int h, input int v);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    compared++;
    if ({rom_addr, rom_en, hit_id, data_valid, data_id} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs got addr=%0d en=%b id=%0d dv=%b did=%0d want all 0", rom_addr, rom_en, hit_id, data_valid, data_id);
    end
`ifdef SPRITE_ARB_COLLIDE_EN
    compared++;
    if (collide !== 1'b0) begin mismatched++; $display("FAIL reset_collide got %b want 0", collide); end
`endif
    tick();
    rst = 1'b0;
    tick();
    sprite_en = 5'b11111;
    place(0, 100, 50);
    probe(100, 50);
    compared++;
    if (rom_en !== 1'b0) begin mismatched++; $display("FAIL no_frame_start_hit got rom_en=%b want 0", rom_en); end
  endtask

  task automatic test_latch_priority();
    place(1, 700, 400); place(2, 700, 400); place(3, 700, 400); place(4, 700, 400);
    latch(5'b11111);
    probe(100, 50);
    compared++;
    if ({rom_addr, rom_en, hit_id} !== {14'd0, 1'b1, 3'd0}) begin
      mismatched++;
      $display("FAIL latch_rom got addr=%0d en=%b id=%0d want 0/1/0", rom_addr, rom_en, hit_id);
    end
    tick();
    compared++;
    if ({data_valid, data_id} !== {1'b1, 3'd0}) begin
      mismatched++;
      $display("FAIL latch_data got dv=%b did=%0d want 1/0", data_valid, data_id);
    end
    tick();
    compared++;
    if (data_valid !== 1'b0) begin mismatched++; $display("FAIL latch_data_drop got dv=%b want 0", data_valid); end
  endtask

  task automatic test_base_offset();
    place(2, 200, 200);
    latch(5'b00100);
    probe(241, 241);
    compared++;
    if ({rom_addr, rom_en, hit_id} !== {14'd5291, 1'b1, 3'd2}) begin
      mismatched++;
      $display("FAIL base_far got addr=%0d en=%b id=%0d want 5291/1/2", rom_addr, rom_en, hit_id);
    end
    tick();
    compared++;
    if ({data_valid, data_id} !== {1'b1, 3'd2}) begin
      mismatched++;
      $display("FAIL base_data got dv=%b did=%0d want 1/2", data_valid, data_id);
    end
    probe(200, 200);
    compared++;
    if ({rom_addr, hit_id} !== {14'd3528, 3'd2}) begin
      mismatched++;
      $display("FAIL base_origin got addr=%0d id=%0d want 3528/2", rom_addr, hit_id);
    end
  endtask

  task automatic test_overlap();
    place(0, 290, 290);
    place(3, 280, 280);
    latch(5'b11111);
    probe(300, 300);
    compared++;
    if ({rom_addr, rom_en, hit_id} !== {14'd430, 1'b1, 3'd0}) begin
      mismatched++;
      $display("FAIL overlap_player got addr=%0d en=%b id=%0d want 430/1/0", rom_addr, rom_en, hit_id);
    end
    latch(5'b11110);
    probe(300, 300);
    compared++;
    if ({rom_addr, rom_en, hit_id} !== {14'd6152, 1'b1, 3'd3}) begin
      mismatched++;
      $display("FAIL overlap_ghost got addr=%0d en=%b id=%0d want 6152/1/3", rom_addr, rom_en, hit_id);
    end
    latch(5'b00000);
    probe(300, 300);
    compared++;
    if (rom_en !== 1'b0) begin mismatched++; $display("FAIL disabled_overlap got rom_en=%b want 0", rom_en); end
  endtask

  task automatic test_edge_clip();
    place(1, 600, 0);
    latch(5'b00010);
    probe(642, 0);
    compared++;
    if (rom_en !== 1'b0) begin mismatched++; $display("FAIL edge_right got rom_en=%b want 0", rom_en); end
    probe(599, 0);
    compared++;
    if (rom_en !== 1'b0) begin mismatched++; $display("FAIL edge_left got rom_en=%b want 0", rom_en); end
    probe(641, 41);
    compared++;
    if ({rom_addr, rom_en, hit_id} !== {14'd3527, 1'b1, 3'd1}) begin
      mismatched++;
      $display("FAIL edge_corner got addr=%0d en=%b id=%0d want 3527/1/1", rom_addr, rom_en, hit_id);
    end
    probe(641, 42);
    compared++;
    if (rom_en !== 1'b0) begin mismatched++; $display("FAIL edge_bottom got rom_en=%b want 0", rom_en); end
    place(1, 1000, 0);
    latch(5'b00010);
    probe(1023, 0);
    compared++;
    if ({rom_addr, rom_en} !== {14'd1787, 1'b1}) begin
      mismatched++;
      $display("FAIL clip_1023 got addr=%0d en=%b want 1787/1", rom_addr, rom_en);
    end
    probe(10, 0);
    compared++;
    if (rom_en !== 1'b0) begin mismatched++; $display("FAIL clip_nowrap got rom_en=%b want 0", rom_en); end
    place(4, 0, 0);
    latch(5'b10000);
    probe(41, 41);
    compared++;
    if ({rom_addr, rom_en, hit_id} !== {14'd8819, 1'b1, 3'd4}) begin
      mismatched++;
      $display("FAIL last_word got addr=%0d en=%b id=%0d want 8819/1/4", rom_addr, rom_en, hit_id);
    end
  endtask

  task automatic test_midframe();
    place(0, 100, 100);
    latch(5'b00001);
    place(0, 500, 100);
    probe(100, 100);
    compared++;
    if ({rom_addr, rom_en} !== {14'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL mid_old_pos got addr=%0d en=%b want 0/1", rom_addr, rom_en);
    end
    probe(500, 100);
    compared++;
    if (rom_en !== 1'b0) begin mismatched++; $display("FAIL mid_new_early got rom_en=%b want 0", rom_en); end
    h_cnt = 10'd100;
    v_cnt = 10'd100;
    pix_valid = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pix_valid = 1'b0;
    tick();
    compared++;
    if (rom_en !== 1'b1) begin mismatched++; $display("FAIL fs_same_pixel got rom_en=%b want 1", rom_en); end
    probe(500, 100);
    compared++;
    if ({rom_addr, rom_en} !== {14'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL mid_new_pos got addr=%0d en=%b want 0/1", rom_addr, rom_en);
    end
    h_cnt = 10'd510;
    pix_valid = 1'b1;
    tick(); tick(); tick();
    compared++;
    if ({rom_en, data_valid, rom_addr} !== {1'b1, 1'b1, 14'd10}) begin
      mismatched++;
      $display("FAIL pre_reset got en=%b dv=%b addr=%0d want 1/1/10", rom_en, data_valid, rom_addr);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({rom_en, data_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL async_reset got en=%b dv=%b want 0/0", rom_en, data_valid);
    end
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    compared++;
    if ({rom_en, data_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL post_reset got en=%b dv=%b want 0/0", rom_en, data_valid);
    end
    pix_valid = 1'b0;
    latch(5'b00001);
    probe(510, 100);
    compared++;
    if ({rom_addr, rom_en} !== {14'd10, 1'b1}) begin
      mismatched++;
      $display("FAIL relatch got addr=%0d en=%b want 10/1", rom_addr, rom_en);
    end
  endtask

`ifdef SPRITE_ARB_COLLIDE_EN
  task automatic test_collide();
    place(0, 100, 100);
    place(4, 120, 120);
    latch(5'b10001);
    probe(130, 130);
    tick();
    compared++;
    if (collide !== 1'b0) begin mismatched++; $display("FAIL collide_early got %b want 0", collide); end
    place(4, 500, 500);
    latch(5'b10001);
    compared++;
    if (collide !== 1'b1) begin mismatched++; $display("FAIL collide_pulse got %b want 1", collide); end
    tick();
    compared++;
    if (collide !== 1'b0) begin mismatched++; $display("FAIL collide_width got %b want 0", collide); end
    probe(130, 130);
    probe(510, 510);
    latch(5'b10001);
    compared++;
    if (collide !== 1'b0) begin mismatched++; $display("FAIL collide_separated got %b want 0", collide); end
  endtask
`endif

  initial begin
    test_reset();
    test_latch_priority();
    test_base_offset();
    test_overlap();
    test_edge_clip();
    test_midframe();
`ifdef SPRITE_ARB_COLLIDE_EN
    test_collide();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM between the player and ghost sprites.
- Every pixel clock it determines which enabled sprite, if any, covers the current (h_cnt, v_cnt).
- It picks the highest-priority sprite, which is the lowest index; the player is index 0.
- It issues the ROM read address as sprite_base + row*SIZE + col.
- It tags the returning ROM data with the sprite id so the VGA mixer can colour it.
- Sprite positions are double-buffered per frame so sprites do not tear.

Parameters:
- NUM_SPR, 5, number of sprites (0 = player, 1..4 = ghosts).
- SIZE, 42, sprite edge length in pixels; each sprite image is SIZE*SIZE words.
- ADDR_W, 14, ROM address width; must satisfy NUM_SPR*SIZE*SIZE ≤ 2^ADDR_W.
- ID_W, 3, sprite id width.

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: asynchronous, active-high reset.
- h_cnt, in, 10: current pixel column.
- v_cnt, in, 10: current pixel row.
- pix_valid, in, 1: high when the pixel is in the visible area.
- frame_start, in, 1: one-cycle pulse at the start of each frame.
- sprite_en, in, NUM_SPR: per-sprite enable.
- sprite_x, in, NUM_SPR*10: top-left x of each sprite; sprite i occupies bits [10i+9:10i].
- sprite_y, in, NUM_SPR*10: top-left y of each sprite, same packing.
- rom_addr, out, ADDR_W: ROM read address.
- rom_en, out, 1: ROM read enable.
- hit_id, out, ID_W: sprite id, aligned with rom_addr.
- data_valid, out, 1: ROM data for this pixel is a sprite pixel.
- data_id, out, ID_W: sprite id, aligned with the ROM data (one cycle after rom_addr).
- collide, out, 1: collision pulse; exists only when the optional feature below is compiled in.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. While rst is high, every output, shadow register and pipeline register is 0, including shadow enables. In-flight pipeline contents are discarded, and no hits occur until the first frame_start after reset.
- Shadow registers: on a clk edge with frame_start=1, sprite_en/x/y are copied into shadow registers. All hit logic uses only the shadows.
- frame_start coinciding with pix_valid: that pixel is evaluated with the pre-update shadows.
- Hit test for sprite i: shadow_en[i] && pix_valid && h_cnt ≥ x_i && h_cnt < x_i+SIZE && v_cnt ≥ y_i && v_cnt < y_i+SIZE.
  - x_i+SIZE and y_i+SIZE are computed at 11 bits, so there is no wrap.
  - A sprite extending past 1023 clips naturally.
- Pipeline stage 1, registered at input cycle n+1: per-sprite hit vector; col=h_cnt−x and row=v_cnt−y, each 6 bits, for every sprite.
- Pipeline stage 2, registered at n+2:
  - Priority select of the lowest-index hit.
  - rom_addr = id*SIZE*SIZE + row*SIZE + col, computed at ADDR_W bits, no modulo.
  - rom_en=1 and hit_id=id.
  - With no hit: rom_en=0, rom_addr=0, hit_id=0.
- Stage 3, registered at n+3: data_valid=previous rom_en and data_id=previous hit_id. This matches a ROM with 1-cycle read latency.
- Throughput: one pixel per clock with no stalls. Total latency is 2 cycles to rom_addr and 3 cycles to data_valid.
- Simultaneous hits: the lower index always wins, so the player is drawn over ghosts and ghost 1 over ghost 4.
- Boundaries:
  - col and row range 0..SIZE−1 inside a hit.
  - The last sprite word is NUM_SPR*SIZE*SIZE−1, which is 8819 for the defaults.
  - A disabled sprite never hits, even if its coordinates overlap the pixel.

Optional Feature:
- Macro: SPRITE_ARB_COLLIDE_EN.
- With the macro defined:
  - A sticky flag sets when, in any visible pixel, stage-1 hit[0] and hit[k] for any k≥1 are both set.
  - On frame_start, collide pulses high for one cycle if the flag is set, then the flag clears.
  - A collision in the same cycle as frame_start counts toward the next frame.
  - rst clears both the flag and collide.
- Without the macro: no collide port and no collision logic.

Test Plan:
- Shadow latch and priority:
  - Stimulus: rst, then frame_start with sprite 0 at (100,50), all enabled; drive pixel (100,50) with pix_valid=1.
  - Response: two cycles later rom_addr=0, rom_en=1, hit_id=0; one cycle after that data_valid=1, data_id=0.
- Sprite base offset:
  - Stimulus: only sprite 2 enabled at (200,200); pixel (241,241).
  - Response: rom_addr = 2*1764+41*42+41 = 5291, hit_id=2.
- Overlap:
  - Stimulus: sprites 0 and 3 both cover (300,300).
  - Response: hit_id=0. With sprite 0 disabled, hit_id=3.
- Edge and clip:
  - Stimulus: sprite 1 at (600,0); pixels (642,0), (599,0) and (641,41).
  - Response: rom_en=0 for the first two; the third gives rom_addr=1764+1763=3527. With x=1000, pixel (1023,0) gives col=23 and there is no wrap.
- Mid-frame update and mid-frame reset:
  - Stimulus: change sprite_x mid-frame without frame_start.
  - Response: hits still use the old position until frame_start. Asserting rst mid-frame drops rom_en/data_valid to 0 immediately, and nothing hits until the next frame_start.
- Collision (SPRITE_ARB_COLLIDE_EN):
  - Stimulus: player at (100,100) and ghost 4 at (120,120), one frame scanned, then frame_start.
  - Response: collide=1 for exactly one cycle. The next frame, with the sprites separated, gives collide=0.
